qam64_symbol_packer: RTL and testbench
======================================

// Module: qam64_symbol_packer
// PURPOSE
//  Data-clock-domain stage fed by the reset block's rst_data output. Packs an
//  incoming byte stream into 6-bit 64-QAM symbols and Gray-maps each symbol to
//  signed I/Q amplitude levels in {-7,-5,-3,-1,+1,+3,+5,+7}. Valid/ready on both
//  sides. Output feeds the DSP-side pulse shaper through its CDC FIFO.
// PARAMETERS
//  OUT_W  4   width of sym_i/sym_q, two's complement, sign-extended; must be >=4
//  GRAY   1   1: Gray level map; 0: natural binary map (000->-7 ... 111->+7)
//  CNT_W  16  width of sym_count
// PORTS
//  data_clk   in   1      clock; all logic on rising edge
//  rst_data   in   1      reset, synchronous, active-high
//  in_data    in   8      input byte; MSB is transmitted first
//  in_valid   in   1      in_data valid
//  in_ready   out  1      byte accepted when in_valid && in_ready
//  sym_i      out  OUT_W  in-phase level
//  sym_q      out  OUT_W  quadrature level
//  sym_valid  out  1      sym_i/sym_q valid
//  sym_ready  in   1      symbol consumed when sym_valid && sym_ready
//  sym_count  out  CNT_W  count of symbols consumed since reset, wraps to 0
// BEHAVIOUR
//  - Reset (rst_data=1 at edge): bit accumulator, fill count, sym_valid,
//    sym_i, sym_q, sym_count all cleared to 0. Partial bits are discarded.
//    in_ready=0 while rst_data is high.
//  - Accumulator: 14-bit FIFO of bits, fill cnt 0..14; oldest bit first.
//  - ext = (cnt>=6) && (!sym_valid || sym_ready): the 6 oldest bits load the
//    output register; sym_valid=1 on the next cycle. Latency: byte accepted at
//    edge N -> first symbol visible after edge N+1.
//  - in_ready = !rst_data && ((cnt - (ext ? 6 : 0)) <= 6). Combinational path
//    from sym_ready to in_ready is intentional; it enables 4 symbols / 3 bytes.
//  - Same-cycle accept + ext: cnt_next = cnt + 8 - 6. New byte is appended
//    after remaining bits, MSB first.
//  - sym_valid && !sym_ready: sym_i/q/valid hold; no ext; accumulation
//    continues until in_ready falls. No byte is ever dropped or duplicated.
//  - Symbol bits b5..b0 (b5 oldest): I from b5b4b3, Q from b2b1b0.
//    GRAY=1: 000:-7 001:-5 011:-3 010:-1 110:+1 111:+3 101:+5 100:+7.
//  - sym_count increments on each sym_valid && sym_ready; wraps at 2^CNT_W-1.
//  - After (sym_valid && sym_ready) with no ext, sym_valid drops to 0 on the
//    next cycle.
// CONFIGURATION
//  QAM_SCRAMBLE_EN defined: each accepted bit is XORed with PRBS7 (x^7+x^6+1,
//    Fibonacci; out=s6^s5; s<={s5..s0,out}) before entering the accumulator.
//    8 PRBS steps per accepted byte. Seed 7'h7F on reset. First keystream byte
//    is 0x02.
//  QAM_SCRAMBLE_EN undefined: bits pass unscrambled; no PRBS logic present.
// TESTING
//  1 Bytes 0x05,0xAD,0xEC back-to-back, sym_ready=1 -> (I,Q) = (-7,-5),
//    (-3,-1),(+1,+3),(+5,+7); sym_count=4.
//  2 Stream 300 random bytes, in_valid=1, sym_ready=1 -> steady state 3 bytes
//    accepted per 4 cycles, 400 symbols out, match scoreboard.
//  3 sym_ready=0 for 10 cycles mid-stream -> in_ready falls once cnt would
//    exceed 6; sym_i/q held stable; no loss when sym_ready returns to 1.
//  4 Accept 1 byte 0xFF (one symbol (+3,+3), 2 bits left), then pulse rst_data
//    -> sym_valid=0, sym_count=0; next 0x05,0xAD,0xEC yields case-1 symbols.
//  5 GRAY=0, byte stream 0x00,0x00,0x00 -> 4 x (-7,-7); 0xFF x3 -> 4 x (+7,+7).
//  6 QAM_SCRAMBLE_EN, after reset feed 0x00 -> scrambled bits 0000_0010;
//    first symbol (-7,-7); matches PRBS7 reference model over 1000 bytes.

Source files
------------

// File: rtl/qam64_symbol_packer.sv
// ---------------------------------------------------------------------------
// qam64_symbol_packer
//
// Packs a byte stream (MSB first) into 6-bit 64-QAM symbols and maps each
// symbol onto signed I/Q amplitude levels {-7,-5,-3,-1,+1,+3,+5,+7}.
// The oldest three bits of a symbol select I and the next three select Q.
// Both sides use valid/ready handshaking.
//
// Parameters:
//   OUT_W  width of sym_i/sym_q (two's complement, sign-extended, >= 4)
//   GRAY   1: Gray-coded level map, 0: natural binary level map
//   CNT_W  width of sym_count
//
// Ports:
//   data_clk   clock, all logic on the rising edge
//   rst_data   synchronous active-high reset
//   in_data    input byte, MSB transmitted first
//   in_valid   in_data valid
//   in_ready   byte accepted when in_valid && in_ready
//   sym_i      in-phase level
//   sym_q      quadrature level
//   sym_valid  sym_i/sym_q valid
//   sym_ready  symbol consumed when sym_valid && sym_ready
//   sym_count  symbols consumed since reset, wraps to 0
//
// Optional feature:
//   QAM_SCRAMBLE_EN  when defined, every accepted bit is XORed with a PRBS7
//                    keystream (x^7+x^6+1, seed 7'h7F) before packing.
// ---------------------------------------------------------------------------
module qam64_symbol_packer #(
    parameter int OUT_W = 4,
    parameter bit GRAY  = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             data_clk,
    input  logic             rst_data,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] sym_i,
    output logic [OUT_W-1:0] sym_q,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [CNT_W-1:0] sym_count
);

    // Bit accumulator: acc[13] is the oldest bit; bits below the fill count
    // are always zero so a new byte can simply be ORed in.
    logic [13:0] acc;
    logic [13:0] acc_shift;
    logic [13:0] acc_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_shift;
    logic [3:0]  cnt_next;
    logic        ext;
    logic        accept;
    logic [7:0]  byte_bits;

    // Maps a 3-bit code to a 4-bit signed level 2*idx-7.  Subtracting 8 from
    // {idx,1} is the same as inverting its MSB.
    function automatic logic [3:0] level(input logic [2:0] code);
        logic [2:0] idx;
        if (GRAY) begin
            idx[2] = code[2];
            idx[1] = code[2] ^ code[1];
            idx[0] = code[2] ^ code[1] ^ code[0];
        end else begin
            idx = code;
        end
        return {~idx[2], idx[1:0], 1'b1};
    endfunction

`ifdef QAM_SCRAMBLE_EN
    logic [6:0] prbs;
    logic [6:0] prbs_next;
    logic [7:0] keystream;

    // Eight PRBS steps per byte; the first keystream bit covers the byte MSB.
    always_comb begin
        prbs_next = prbs;
        keystream = '0;
        for (int k = 7; k >= 0; k--) begin
            keystream[k] = prbs_next[6] ^ prbs_next[5];
            prbs_next    = {prbs_next[5:0], keystream[k]};
        end
    end

    assign byte_bits = in_data ^ keystream;

    always_ff @(posedge data_clk) begin
        if (rst_data) begin
            prbs <= 7'h7F;
        end else if (accept) begin
            prbs <= prbs_next;
        end
    end
`else
    assign byte_bits = in_data;
`endif

    // Extraction frees 6 bits in the same cycle, so in_ready looks at the
    // post-extraction fill; this sym_ready->in_ready path is what allows
    // 3 bytes in per 4 symbols out.
    always_comb begin
        ext       = (cnt >= 4'd6) && (!sym_valid || sym_ready);
        cnt_shift = ext ? (cnt - 4'd6) : cnt;
        acc_shift = ext ? {acc[7:0], 6'b0} : acc;
        in_ready  = !rst_data && (cnt_shift <= 4'd6);
        accept    = in_valid && in_ready;
        acc_next  = acc_shift;
        cnt_next  = cnt_shift;
        if (accept) begin
            acc_next = acc_shift | ({byte_bits, 6'b0} >> cnt_shift);
            cnt_next = cnt_shift + 4'd8;
        end
    end

    always_ff @(posedge data_clk) begin
        if (rst_data) begin
            acc       <= '0;
            cnt       <= '0;
            sym_valid <= 1'b0;
            sym_i     <= '0;
            sym_q     <= '0;
            sym_count <= '0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (ext) begin
                sym_i     <= OUT_W'($signed(level(acc[13:11])));
                sym_q     <= OUT_W'($signed(level(acc[10:8])));
                sym_valid <= 1'b1;
            end else if (sym_ready) begin
                sym_valid <= 1'b0;
            end
            if (sym_valid && sym_ready) begin
                sym_count <= sym_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_qam64_symbol_packer.sv
// ---------------------------------------------------------------------------
// tb_qam64_symbol_packer
//
// Self-checking bench for qam64_symbol_packer.  Stimulus pushes expected
// symbols into a queue (hand-computed for directed vectors, a bit-level
// reference model for random streams); monitors pop and compare whenever a
// DUT presents a symbol.  A second instance runs the natural binary map.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qam64_symbol_packer;

    typedef struct {
        int i;
        int q;
    } sym_t;

    logic        data_clk = 1'b0;
    logic        rst_data = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  sym_i;
    logic [3:0]  sym_q;
    logic        sym_valid;
    logic        sym_ready = 1'b1;
    logic [15:0] sym_count;

    logic [7:0]  in_data2 = '0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [5:0]  sym_i2;
    logic [5:0]  sym_q2;
    logic        sym_valid2;
    logic        sym_ready2 = 1'b1;
    logic [15:0] sym_count2;

    int   checks_total = 0;
    int   checks_passed = 0;
    int   pops = 0;
    int   pops_nat = 0;
    int   cyc = 0;
    bit   use_model = 1'b0;
    sym_t exp_q[$];
    sym_t exp_nat_q[$];
    logic [7:0] stim_bytes[$];
    sym_t stim_exp[$];
    bit   model_bits[$];
    logic [6:0] model_prbs = 7'h7F;
    int   gray_tab[8] = '{-7, -5, -1, -3, 7, 5, 1, 3};

`ifdef QAM_SCRAMBLE_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    always #5 data_clk = ~data_clk;

    always @(posedge data_clk) cyc++;

    qam64_symbol_packer #(.OUT_W(4), .GRAY(1'b1), .CNT_W(16)) dut (
        .data_clk  (data_clk),
        .rst_data  (rst_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sym_i     (sym_i),
        .sym_q     (sym_q),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_count (sym_count)
    );

    qam64_symbol_packer #(.OUT_W(6), .GRAY(1'b0), .CNT_W(16)) dut_nat (
        .data_clk  (data_clk),
        .rst_data  (rst_data),
        .in_data   (in_data2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .sym_i     (sym_i2),
        .sym_q     (sym_q2),
        .sym_valid (sym_valid2),
        .sym_ready (sym_ready2),
        .sym_count (sym_count2)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: keeps a plain bit queue and emits a symbol per 6 bits.
    task automatic modelAccept(input logic [7:0] b);
        logic [7:0] v;
        logic [2:0] ci;
        logic [2:0] cq;
        sym_t s;
        v = b;
`ifdef QAM_SCRAMBLE_EN
        for (int k = 7; k >= 0; k--) begin
            logic ks;
            ks = model_prbs[6] ^ model_prbs[5];
            model_prbs = {model_prbs[5:0], ks};
            v[k] = v[k] ^ ks;
        end
`endif
        for (int k = 7; k >= 0; k--) model_bits.push_back(v[k]);
        while (model_bits.size() >= 6) begin
            ci = {model_bits[0], model_bits[1], model_bits[2]};
            cq = {model_bits[3], model_bits[4], model_bits[5]};
            repeat (6) void'(model_bits.pop_front());
            s.i = gray_tab[ci];
            s.q = gray_tab[cq];
            exp_q.push_back(s);
        end
    endtask

    // Monitor for the Gray-mapped instance; also feeds the model on accepts.
    always @(negedge data_clk) begin
        if (!rst_data) begin
            if (in_valid && in_ready && use_model) modelAccept(in_data);
            if (sym_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_symbol", int'(sym_valid), 0);
                end else begin
                    checkOutput($sformatf("sym_i[%0d]", pops), int'($signed(sym_i)), exp_q[0].i);
                    checkOutput($sformatf("sym_q[%0d]", pops), int'($signed(sym_q)), exp_q[0].q);
                    if (sym_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    // Monitor for the natural-map instance.
    always @(negedge data_clk) begin
        if (!rst_data && sym_valid2) begin
            if (exp_nat_q.size() == 0) begin
                checkOutput("nat_unexpected_symbol", int'(sym_valid2), 0);
            end else begin
                checkOutput($sformatf("nat_sym_i[%0d]", pops_nat), int'($signed(sym_i2)), exp_nat_q[0].i);
                checkOutput($sformatf("nat_sym_q[%0d]", pops_nat), int'($signed(sym_q2)), exp_nat_q[0].q);
                if (sym_ready2) begin
                    void'(exp_nat_q.pop_front());
                    pops_nat++;
                end
            end
        end
    end

    task automatic setModel(input bit m);
        use_model = m | SCR;
    endtask

    task automatic pushStim(input int i, input int q);
        sym_t s;
        s.i = i;
        s.q = q;
        stim_exp.push_back(s);
    endtask

    task automatic doReset();
        rst_data  = 1'b1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        sym_ready = 1'b1;
        @(negedge data_clk);
        checkOutput("in_ready_during_reset", int'(in_ready), 0);
        @(posedge data_clk); #1;
        @(posedge data_clk); #1;
        rst_data = 1'b0;
        exp_q.delete();
        exp_nat_q.delete();
        model_bits.delete();
        model_prbs = 7'h7F;
        pops = 0;
        pops_nat = 0;
        @(negedge data_clk);
        checkOutput("reset_sym_valid", int'(sym_valid), 0);
        checkOutput("reset_sym_count", int'(sym_count), 0);
        checkOutput("reset_sym_i", int'(sym_i), 0);
        checkOutput("reset_sym_q", int'(sym_q), 0);
        @(posedge data_clk); #1;
    endtask

    task automatic sendByte(input bit nat, input logic [7:0] b, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        if (nat) begin
            in_data2  = b;
            in_valid2 = 1'b1;
        end else begin
            in_data  = b;
            in_valid = 1'b1;
        end
        while (!ok && waited < 50) begin
            @(negedge data_clk);
            if (nat ? in_ready2 : in_ready) ok = 1'b1;
            else waited++;
        end
        @(posedge data_clk); #1;
    endtask

    task automatic applyStimulus(input bit nat);
        bit ok;
        int nacc;
        nacc = 0;
        if (nat) foreach (stim_exp[k]) exp_nat_q.push_back(stim_exp[k]);
        else if (!use_model) foreach (stim_exp[k]) exp_q.push_back(stim_exp[k]);
        foreach (stim_bytes[k]) begin
            sendByte(nat, stim_bytes[k], ok);
            if (ok) nacc++;
        end
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        checkOutput("bytes_accepted", nacc, stim_bytes.size());
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_nat_q.size() != 0) && n < 100) begin
            @(posedge data_clk); #1;
            n++;
        end
        checkOutput({name, "_symbols_left"}, exp_q.size() + exp_nat_q.size(), 0);
        @(negedge data_clk);
        checkOutput({name, "_sym_valid_idle"}, int'(sym_valid), 0);
        checkOutput({name, "_sym_count"}, int'(sym_count), pops);
        checkOutput({name, "_nat_sym_count"}, int'(sym_count2), pops_nat);
        @(posedge data_clk); #1;
    endtask

    task automatic loadCase1();
        stim_bytes = '{8'h05, 8'hAD, 8'hEC};
        stim_exp.delete();
        pushStim(-7, -5);
        pushStim(-3, -1);
        pushStim(1, 3);
        pushStim(5, 7);
    endtask

    task automatic loadRandom(input int n);
        stim_bytes.delete();
        stim_exp.delete();
        for (int k = 0; k < n; k++) stim_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_cyc;
        int elapsed;
        bit ok;
        int n;

        // Case 1: directed bytes, each Gray level appears once
        setModel(1'b0);
        doReset();
        loadCase1();
        applyStimulus(1'b0);
        drain("case1");
        checkOutput("case1_sym_count_4", int'(sym_count), 4);

        // Case 2: 300 random bytes at full rate, 3 bytes per 4 cycles
        doReset();
        setModel(1'b1);
        loadRandom(300);
        start_cyc = cyc;
        applyStimulus(1'b0);
        elapsed = cyc - start_cyc;
        checkOutput("case2_cycles_within_400", int'(elapsed <= 400), 1);
        drain("case2");
        checkOutput("case2_sym_count_400", int'(sym_count), 400);

        // Case 3: 11-cycle sym_ready stall mid-stream
        doReset();
        setModel(1'b1);
        loadRandom(60);
        fork
            applyStimulus(1'b0);
            begin
                repeat (20) @(posedge data_clk);
                #1;
                sym_ready = 1'b0;
                repeat (10) @(posedge data_clk);
                @(negedge data_clk);
                checkOutput("case3_in_ready_low_in_stall", int'(in_ready), 0);
                checkOutput("case3_sym_valid_held", int'(sym_valid), 1);
                @(posedge data_clk); #1;
                sym_ready = 1'b1;
            end
        join
        drain("case3");
        checkOutput("case3_sym_count_80", int'(sym_count), 80);

        // Case 4: partial bits discarded by reset
        doReset();
        setModel(1'b0);
        stim_bytes = '{8'hFF};
        stim_exp.delete();
        pushStim(3, 3);
        applyStimulus(1'b0);
        drain("case4a");
        checkOutput("case4_sym_count_1", int'(sym_count), 1);
        doReset();
        loadCase1();
        applyStimulus(1'b0);
        drain("case4b");
        checkOutput("case4_sym_count_4", int'(sym_count), 4);

`ifndef QAM_SCRAMBLE_EN
        // Case 5: natural binary map, sign-extended to 6 bits
        doReset();
        stim_bytes = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        stim_exp.delete();
        repeat (4) pushStim(-7, -7);
        repeat (4) pushStim(7, 7);
        applyStimulus(1'b1);
        drain("case5");
        checkOutput("case5_nat_sym_count_8", int'(sym_count2), 8);
`else
        // Case 6: scrambled 0x00 becomes 0000_0010, first symbol (-7,-7)
        doReset();
        setModel(1'b1);
        sendByte(1'b0, 8'h00, ok);
        in_valid = 1'b0;
        n = 0;
        @(negedge data_clk);
        while (!sym_valid && n < 20) begin
            @(negedge data_clk);
            n++;
        end
        checkOutput("case6_first_sym_i", int'($signed(sym_i)), -7);
        checkOutput("case6_first_sym_q", int'($signed(sym_q)), -7);
        @(posedge data_clk); #1;
        loadRandom(1000);
        applyStimulus(1'b0);
        drain("case6");
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
